// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seg_scan display driver.
// Segment patterns are {a,b,c,d,e,f,g,dp}, active-high.
package seg_scan_pkg;

   localparam logic [7:0] SEG_0 = 8'b1111_1100;
   localparam logic [7:0] SEG_1 = 8'b0110_0000;
   localparam logic [7:0] SEG_2 = 8'b1101_1010;
   localparam logic [7:0] SEG_3 = 8'b1111_0010;
   localparam logic [7:0] SEG_4 = 8'b0110_0110;
   localparam logic [7:0] SEG_5 = 8'b1011_0110;
   localparam logic [7:0] SEG_6 = 8'b1011_1110;
   localparam logic [7:0] SEG_7 = 8'b1110_0000;
   localparam logic [7:0] SEG_8 = 8'b1111_1110;
   localparam logic [7:0] SEG_9 = 8'b1111_0110;
   localparam logic [7:0] BLANK = 8'h00;

   localparam int NDIGITS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   function automatic logic [7:0] seg_encode(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         4'd5:    p = SEG_5;
         4'd6:    p = SEG_6;
         4'd7:    p = SEG_7;
         4'd8:    p = SEG_8;
         4'd9:    p = SEG_9;
         default: p = BLANK;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bin2bcd5.sv
// Sequential 5-bit double-dabble: one shift-add-3 step per cycle.
// busy_o is high while further steps follow the current one.
module bin2bcd5
   import seg_scan_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [4:0] value_i,
   output logic       busy_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   logic [4:0] bin_q, bin_d;
   logic [7:0] bcd_q, bcd_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] t_adj, o_adj;

   // Load on start, otherwise perform one adjust-and-shift step per cycle.
   always_comb begin
      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      t_adj = bcd_q[7:4] + ((bcd_q[7:4] >= 4'd5) ? 4'd3 : 4'd0);
      o_adj = bcd_q[3:0] + ((bcd_q[3:0] >= 4'd5) ? 4'd3 : 4'd0);
      if (start_i) begin
         bin_d = value_i;
         bcd_d = '0;
         cnt_d = 3'd5;
      end else if (cnt_q != 3'd0) begin
         {bcd_d, bin_d} = {t_adj, o_adj, bin_q} << 1;
         cnt_d = cnt_q - 3'd1;
      end
   end

   // Scratch and step counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q > 3'd1);
   assign tens_o = bcd_q[7:4];
   assign ones_o = bcd_q[3:0];

endmodule

// File: rtl/seg_scan.sv
// Two-digit decimal display of a 5-bit sum on an 8-digit
// multiplexed seven-segment panel with a continuous scan.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int unsigned DIV = 4
)
(
   input  logic               CLK_i,
   input  logic               CLR_i,
   input  logic               ld_i,
   input  logic [4:0]         sum_i,
   output logic               busy_o,
   output logic [7:0]         ans_o,
   output logic [NDIGITS-1:0] bit_o
);

   localparam int          IW   = $clog2(NDIGITS);
   localparam logic [15:0] LAST = 16'(DIV - 1);

   state_e state_q, state_d;
   logic   start, commit;
   logic   bcd_busy;
   logic [3:0] bcd_tens, bcd_ones;
   logic [3:0] tens_q, ones_q, tens_d, ones_d;
   logic [15:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0] ans_q, ans_d;
   logic [NDIGITS-1:0] bit_q, bit_d;

   assign start = (state_q == IDLE) && ld_i;

   bin2bcd5 u_bcd (
      .clk_i   (CLK_i),
      .rst_i   (CLR_i),
      .start_i (start),
      .value_i (sum_i),
      .busy_o  (bcd_busy),
      .tens_o  (bcd_tens),
      .ones_o  (bcd_ones)
   );

   // Conversion control: idle, wait out the steps, then one commit cycle.
   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         IDLE:    if (ld_i) state_d = CONV;
         CONV:    if (!bcd_busy) state_d = COMMIT;
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Display value, prescaler and the segment/select pair for the next digit.
   always_comb begin
      tens_d  = commit ? bcd_tens : tens_q;
      ones_d  = commit ? bcd_ones : ones_q;
      presc_d = (presc_q == LAST) ? 16'd0 : presc_q + 16'd1;
      idx_d   = (presc_q == LAST) ? idx_q + 1'b1 : idx_q;
      bit_d   = {{(NDIGITS-1){1'b0}}, 1'b1} << idx_d;
      ans_d   = BLANK;
      if (idx_d == IW'(0))
         ans_d = seg_encode(ones_q);
      else if (idx_d == IW'(1) && tens_q != 4'd0)
         ans_d = seg_encode(tens_q);
   end

   // All control and display state.
   always_ff @(posedge CLK_i or posedge CLR_i) begin
      if (CLR_i) begin
         state_q <= IDLE;
         tens_q  <= '0;
         ones_q  <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         ans_q   <= BLANK;
         bit_q   <= {{(NDIGITS-1){1'b0}}, 1'b1};
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         ans_q   <= ans_d;
         bit_q   <= bit_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign ans_o  = ans_q;
   assign bit_o  = bit_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: table of sums with hand-computed
// digit patterns, plus reset, ignored-load and scan-rate sequences.
module tb_seg_scan;

   logic       clk;
   logic       clr;
   logic       ld;
   logic [4:0] sum;
   logic       busy;
   logic [7:0] ans;
   logic [7:0] bsel;
   logic       busy1;
   logic [7:0] ans1;
   logic [7:0] bsel1;

   int ncmp = 0;
   int nbad = 0;

   typedef struct {
      logic [4:0] s;
      logic [7:0] d0;
      logic [7:0] d1;
   } vec_t;

   vec_t tbl[7];
   logic [7:0] segtab[10];

   seg_scan #(.DIV(4)) dut (
      .CLK_i  (clk),
      .CLR_i  (clr),
      .ld_i   (ld),
      .sum_i  (sum),
      .busy_o (busy),
      .ans_o  (ans),
      .bit_o  (bsel)
   );

   seg_scan #(.DIV(1)) dut1 (
      .CLK_i  (clk),
      .CLR_i  (clr),
      .ld_i   (1'b0),
      .sum_i  (5'd0),
      .busy_o (busy1),
      .ans_o  (ans1),
      .bit_o  (bsel1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rot(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   // Load s and follow busy; noise[k] pulses ld (sum=9) before edge N+k.
   task automatic convert(input logic [4:0] s, input logic [6:0] noise);
      int g = 0;
      while (busy && g < 20) begin
         tick();
         g++;
      end
      chk("idle_before_ld", int'(busy), 0);
      ld = 1'b1;
      sum = s;
      tick();
      ld = 1'b0;
      chk("busy_at_N", int'(busy), 1);
      for (int k = 1; k <= 6; k++) begin
         ld = noise[k];
         if (noise[k]) sum = 5'd9;
         tick();
         ld = 1'b0;
         chk($sformatf("busy_N+%0d", k), int'(busy), (k <= 5) ? 1 : 0);
      end
      sum = s;
   endtask

   task automatic read_digit(input int d, output logic [7:0] pat);
      int g = 0;
      logic [7:0] want;
      want = 8'(1 << d);
      while (bsel !== want && g < 64) begin
         tick();
         g++;
      end
      if (bsel !== want) begin
         ncmp++;
         nbad++;
         $display("FAIL scan_timeout digit %0d: got %b want %b", d, bsel, want);
      end
      pat = ans;
   endtask

   task automatic check_display(input string tag, input logic [7:0] e0,
                                input logic [7:0] e1);
      logic [7:0] p;
      tick();
      read_digit(0, p);
      chk({tag, "_d0"}, int'(p), int'(e0));
      read_digit(1, p);
      chk({tag, "_d1"}, int'(p), int'(e1));
   endtask

   initial begin
      logic [7:0] p;
      logic [7:0] prev;
      logic [7:0] e0, e1;
      int cnt;

      tbl[0] = '{5'd23, 8'b1111_0010, 8'b1101_1010};
      tbl[1] = '{5'd7,  8'b1110_0000, 8'b0000_0000};
      tbl[2] = '{5'd31, 8'b0110_0000, 8'b1111_0010};
      tbl[3] = '{5'd0,  8'b1111_1100, 8'b0000_0000};
      tbl[4] = '{5'd10, 8'b1111_1100, 8'b0110_0000};
      tbl[5] = '{5'd19, 8'b1111_0110, 8'b0110_0000};
      tbl[6] = '{5'd29, 8'b1111_0110, 8'b1101_1010};

      segtab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

      clr = 1'b1;
      ld  = 1'b0;
      sum = 5'd0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_bit", int'(bsel), 8'h01);
      chk("rst_ans", int'(ans), 8'h00);
      tick();
      tick();
      #3 clr = 1'b0;
      tick();
      chk("post_rst_ans", int'(ans), 8'hFC);
      chk("post_rst_bit", int'(bsel), 8'h01);

      foreach (tbl[i]) begin
         convert(tbl[i].s, 7'b0);
         check_display($sformatf("tbl_%0d", tbl[i].s), tbl[i].d0, tbl[i].d1);
      end

      convert(5'd23, 7'b0);
      check_display("d23", 8'hF2, 8'hDA);
      for (int d = 2; d < 8; d++) begin
         read_digit(d, p);
         chk($sformatf("blank_d%0d", d), int'(p), 0);
      end

      convert(5'd23, 7'b010_0100);
      check_display("ignore_ld", 8'hF2, 8'hDA);
      convert(5'd7, 7'b100_0000);
      check_display("ignore_commit_ld", 8'hE0, 8'h00);

      ld = 1'b1;
      sum = 5'd23;
      tick();
      ld = 1'b0;
      tick();
      tick();
      #2 clr = 1'b1;
      #1;
      chk("clr_busy", int'(busy), 0);
      chk("clr_bit", int'(bsel), 8'h01);
      chk("clr_ans", int'(ans), 8'h00);
      tick();
      chk("clr_hold_bit", int'(bsel), 8'h01);
      chk("clr_hold_ans", int'(ans), 8'h00);
      #3 clr = 1'b0;
      tick();
      chk("clr_rel_ans", int'(ans), 8'hFC);
      chk("clr_rel_bit", int'(bsel), 8'h01);
      chk("clr_rel_busy", int'(busy), 0);
      check_display("after_clr", 8'hFC, 8'h00);

      for (int v = 0; v < 32; v++) begin
         convert(5'(v), 7'b0);
         e0 = segtab[v % 10];
         e1 = (v / 10 == 0) ? 8'h00 : segtab[v / 10];
         check_display($sformatf("exh_%0d", v), e0, e1);
      end

      prev = bsel;
      cnt = 0;
      while (bsel === prev && cnt < 10) begin
         tick();
         cnt++;
      end
      prev = bsel;
      for (int c = 0; c < 9; c++) begin
         cnt = 0;
         while (bsel === prev && cnt < 10) begin
            tick();
            cnt++;
         end
         chk("div4_period", cnt, 4);
         chk("div4_seq", int'(bsel), int'(rot(prev)));
         prev = bsel;
      end

      chk("div1_busy", int'(busy1), 0);
      prev = bsel1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("div1_seq", int'(bsel1), int'(rot(prev)));
         if (bsel1 == 8'h01) chk("div1_ans0", int'(ans1), 8'hFC);
         prev = bsel1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 DIV, 4, scan prescaler: cycles per digit, legal range 1..65535.
REQ-002 CLK  input  1  sole clock, all state on rising edge.
REQ-003 CLR  input  1  reset, asynchronous, active-high.
REQ-004 ld  input  1  load strobe; sample sum when idle.
REQ-005 sum  input  5  unsigned adder result 0..31, taken from the 5-bit adder stage.
REQ-006 busy  output  1  conversion in progress; ld ignored while high.
REQ-007 ans  output  8  registered segment pattern {a,b,c,d,e,f,g,dp}, active-high.
REQ-008 bit  output  8  registered one-hot digit select, active-high, bit[0] = rightmost digit.

Function
REQ-009 FSM states IDLE, CONV, COMMIT; busy SHALL be 1 exactly when state != IDLE.
REQ-010 IDLE with ld=1 at edge N: capture sum, clear BCD scratch, go CONV; ld=0 stays IDLE.
REQ-011 CONV: one shift-add-3 (double-dabble) step per cycle, exactly 5 cycles, then COMMIT.
REQ-012 COMMIT: write tens/ones to the display registers in one edge (N+6), go IDLE; no partial value is ever displayed.
REQ-013 ld while busy (including COMMIT cycle) SHALL be ignored, not queued.
REQ-014 Conversion: tens 0..3, ones 0..9, exact for all 32 inputs.
REQ-015 Digit 0 shows ones, always lit (0 shows "0"); digit 1 shows tens, blanked (ans=8'h00) when tens=0; digits 2..7 always blank.
REQ-016 Segment codes (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; dp always 0.
REQ-017 Prescaler counts 0..DIV-1; on wrap digit index increments 0..7, 7 wraps to 0; DIV=1 advances every cycle.
REQ-018 bit SHALL equal 1<<index and ans the pattern for that index, both registered from the same edge (never mismatched).
REQ-019 Scan runs continuously, independent of ld/busy; a COMMIT changes ans from the next edge onward for whichever digit is selected.

Reset
REQ-020 CLR=1 SHALL immediately force: state IDLE, busy 0, prescaler 0, index 0, bit 8'b00000001, ans 8'h00, display value 0, scratch 0.
REQ-021 CLR mid-conversion SHALL abort; pending value never committed.
REQ-022 First edge after CLR release: ans = 8'b11111100 (digit 0 showing "0").

Structure
REQ-023 Package seg_scan_pkg holds: segment code constants 0..9, BLANK=8'h00, NDIGITS=8, FSM state type.
REQ-024 One sub-module bin2bcd5: 5-bit sequential double-dabble (start, value in; busy, tens, ones out); FSM, prescaler, scan mux stay in seg_scan.

Verification
REQ-025 CLR pulse mid-CONV -> busy 0, bit 00000001, ans 00000000 during reset; after release ans 11111100 on digit 0, display 0.
REQ-026 ld with sum=23 at edge N -> busy 1 for 6 cycles, low after N+6; then digit 0 ans 11110010 ("3"), digit 1 ans 11011010 ("2").
REQ-027 sum=7 -> digit 0 ans 11100000, digit 1 ans 00000000 (tens blanked); sum=31 -> "3","1"; sum=0 -> digit 0 "0" only.
REQ-028 After ld sum=23, pulse ld with sum=9 at N+2 and N+5 -> ignored, display stays 23, busy timing unchanged.
REQ-029 DIV=4 -> bit changes every 4 cycles, sequence 00000001..10000000 then 00000001; DIV=1 -> changes every cycle.
REQ-030 Exhaustive sum 0..31 -> tens/ones match integer division by 10 for every value.
